nibble_feeder: RTL and testbench



---
 rtl/nibble_feeder_pkg.sv | 20 ++
 rtl/byte_fifo.sv | 58 +++++
 rtl/nibble_feeder.sv | 113 +++++++++++
 tb/tb_nibble_feeder.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/nibble_feeder_pkg.sv
// Shared types and constants for the nibble feeder.
package nibble_feeder_pkg;

    typedef logic [3:0] nibble_t;
    typedef logic [7:0] byte_t;

    typedef enum logic [1:0] {
        EMPTY,
        FIRST,
        SECOND
    } out_state_t;

    localparam int STALL_CNT_W = 16;

    // Select the nibble to send: the high nibble goes out first when msn_first is set.
    function automatic nibble_t pick_nibble(input byte_t b, input logic first, input logic msn_first);
        return (first == msn_first) ? b[7:4] : b[3:0];
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// Small synchronous FIFO. Full/empty come from the level counter; the read
// port is a combinational peek at the head entry.
module byte_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_full,
    output logic                     o_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] LVL_MAX = (AW+1)'(DEPTH);
    localparam logic [AW:0] LVL_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_level;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_level == LVL_MAX);
    assign o_empty = (r_level == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_data  = r_mem[r_rd_ptr];
    assign o_level = r_level;

    // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_ONE;
                2'b01:   r_level <= r_level - LVL_ONE;
                default: r_level <= r_level;
            endcase
        end
    end

    // Storage write; contents need no reset since level gates every read.
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/nibble_feeder.sv
// Byte-in, nibble-out feeder: byte FIFO followed by a two-nibble output stage.
// Optional stall counter port enabled by NIBBLE_FEEDER_STALL_CNT_EN.
module nibble_feeder
    import nibble_feeder_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter bit MSN_FIRST = 1'b1
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [7:0]               i_byte_data,
    input  logic                     i_byte_valid,
    output logic                     o_byte_ready,
    output logic [3:0]               o_data,
    output logic                     o_data_valid,
    input  logic                     i_data_ready,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_idle
`ifdef NIBBLE_FEEDER_STALL_CNT_EN
    ,
    output logic [STALL_CNT_W-1:0]   o_stall_cnt
`endif
);
    out_state_t r_state;
    byte_t      r_byte;
    byte_t      w_fifo_data;
    logic       w_full;
    logic       w_empty;
    logic       w_push;
    logic       w_pop;

    // Ready looks only at registered fullness, never at a same-cycle pop.
    assign o_byte_ready = i_rst_n && !w_full;
    assign w_push       = i_byte_valid && o_byte_ready;
    // Pop when the output stage is free or is handing off its last nibble.
    assign w_pop        = !w_empty &&
                          ((r_state == EMPTY) || ((r_state == SECOND) && i_data_ready));
    assign o_idle       = w_empty && (r_state == EMPTY);

    byte_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (w_push),
        .i_data  (i_byte_data),
        .i_pop   (w_pop),
        .o_data  (w_fifo_data),
        .o_level (o_level),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Output stage FSM with registered nibble and valid.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state      <= EMPTY;
            r_byte       <= '0;
            o_data       <= '0;
            o_data_valid <= 1'b0;
        end else begin
            unique case (r_state)
                EMPTY: begin
                    if (!w_empty) begin
                        r_byte       <= w_fifo_data;
                        o_data       <= pick_nibble(w_fifo_data, 1'b1, MSN_FIRST);
                        o_data_valid <= 1'b1;
                        r_state      <= FIRST;
                    end
                end
                FIRST: begin
                    if (i_data_ready) begin
                        o_data  <= pick_nibble(r_byte, 1'b0, MSN_FIRST);
                        r_state <= SECOND;
                    end
                end
                SECOND: begin
                    if (i_data_ready) begin
                        if (!w_empty) begin
                            r_byte  <= w_fifo_data;
                            o_data  <= pick_nibble(w_fifo_data, 1'b1, MSN_FIRST);
                            r_state <= FIRST;
                        end else begin
                            o_data_valid <= 1'b0;
                            r_state      <= EMPTY;
                        end
                    end
                end
                default: begin
                    o_data_valid <= 1'b0;
                    r_state      <= EMPTY;
                end
            endcase
        end
    end

`ifdef NIBBLE_FEEDER_STALL_CNT_EN
    logic [STALL_CNT_W-1:0] r_stall_cnt;

    // Saturating count of cycles where the producer is blocked.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_stall_cnt <= '0;
        end else if (i_byte_valid && !o_byte_ready && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
        end
    end

    assign o_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_nibble_feeder.sv
// Self-checking bench for nibble_feeder against a byte-queue reference model.
module tb_nibble_feeder;
    localparam int DEPTH = 4;
    localparam bit MSN   = 1'b1;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    byte_data = '0;
    logic          byte_valid = 1'b0;
    logic          byte_ready;
    logic [3:0]    data;
    logic          data_valid;
    logic          data_ready = 1'b0;
    logic [LW-1:0] level;
    logic          idle;
`ifdef NIBBLE_FEEDER_STALL_CNT_EN
    logic [15:0]   stall_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: bytes waiting in the buffer, plus the byte being sent
    // and how many of its nibbles are still owed downstream.
    logic [7:0] mq[$];
    logic [7:0] m_cur = '0;
    int         m_rem = 0;
    int         m_stall = 0;

    nibble_feeder #(.DEPTH(DEPTH), .MSN_FIRST(MSN)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_byte_data  (byte_data),
        .i_byte_valid (byte_valid),
        .o_byte_ready (byte_ready),
        .o_data       (data),
        .o_data_valid (data_valid),
        .i_data_ready (data_ready),
        .o_level      (level),
        .o_idle       (idle)
`ifdef NIBBLE_FEEDER_STALL_CNT_EN
        ,
        .o_stall_cnt  (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [3:0] m_nib();
        logic first;
        first = (m_rem == 2);
        if (first == MSN) return m_cur[7:4];
        return m_cur[3:0];
    endfunction

    // Advance the model by one clock using the current inputs, then the DUT.
    task automatic tick();
        int  r;
        bit  rdy;
        bit  push;
        if (!rst_n) begin
            mq.delete();
            m_rem   = 0;
            m_cur   = '0;
            m_stall = 0;
        end else begin
            rdy  = (mq.size() < DEPTH);
            push = byte_valid && rdy;
            if (byte_valid && !rdy && m_stall < 65535) m_stall++;
            r = m_rem;
            if (r > 0 && data_ready) r--;
            if (r == 0 && mq.size() > 0) begin
                m_cur = mq.pop_front();
                r = 2;
            end
            if (push) mq.push_back(byte_data);
            m_rem = r;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; byte_valid = 1'b1; byte_data = 8'h77; data_ready = 1'b1;
        tick(); tick();
        n_tests++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", data_valid); end
        n_tests++; if (level !== '0) begin n_fail++; $display("FAIL reset_level: got %0d want 0", level); end
        n_tests++; if (data !== 4'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", data); end
        n_tests++; if (idle !== 1'b1) begin n_fail++; $display("FAIL reset_idle: got %b want 1", idle); end
        n_tests++; if (byte_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", byte_ready); end
`ifdef NIBBLE_FEEDER_STALL_CNT_EN
        n_tests++; if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_stall: got %0d want 0", stall_cnt); end
`endif
        byte_valid = 1'b0; rst_n = 1'b1;
        tick();
        n_tests++; if (byte_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_ready: got %b want 1", byte_ready); end
    endtask

    task automatic test_single();
        data_ready = 1'b1; byte_data = 8'hA5; byte_valid = 1'b1;
        tick();
        byte_valid = 1'b0;
        n_tests++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL single_lat1: valid %b want 0", data_valid); end
        tick();
        n_tests++; if (data_valid !== 1'b1 || data !== 4'hA) begin n_fail++; $display("FAIL single_n0: got v%b %h want v1 a", data_valid, data); end
        tick();
        n_tests++; if (data_valid !== 1'b1 || data !== 4'h5) begin n_fail++; $display("FAIL single_n1: got v%b %h want v1 5", data_valid, data); end
        tick();
        n_tests++; if (data_valid !== 1'b0 || idle !== 1'b1 || level !== '0) begin
            n_fail++; $display("FAIL single_end: got v%b idle%b lvl%0d want v0 idle1 lvl0", data_valid, idle, level);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [3];
        logic [3:0] got[$];
        int first_v = -1;
        int gaps = 0;
        bytes[0] = 8'h12; bytes[1] = 8'h34; bytes[2] = 8'h56;
        data_ready = 1'b1;
        for (int c = 0; c < 14; c++) begin
            byte_valid = (c % 2 == 0) && (c < 6);
            if (c < 6) byte_data = bytes[c/2];
            tick();
            if (data_valid === 1'b1) begin
                got.push_back(data);
                if (first_v < 0) first_v = c;
            end else if (first_v >= 0 && got.size() < 6) begin
                gaps++;
            end
        end
        byte_valid = 1'b0;
        n_tests++; if (got.size() != 6) begin n_fail++; $display("FAIL b2b_count: got %0d nibbles want 6", got.size()); end
        n_tests++; if (gaps != 0) begin n_fail++; $display("FAIL b2b_gaps: got %0d bubbles want 0", gaps); end
        for (int i = 0; i < got.size() && i < 6; i++) begin
            n_tests++; if (got[i] !== 4'(i + 1)) begin n_fail++; $display("FAIL b2b_nib%0d: got %h want %h", i, got[i], i + 1); end
        end
    endtask

    task automatic test_stall();
        data_ready = 1'b0; byte_data = 8'hC3; byte_valid = 1'b1;
        tick();
        byte_valid = 1'b0;
        tick();
        for (int k = 0; k < 5; k++) begin
            n_tests++; if (data_valid !== 1'b1 || data !== 4'hC) begin n_fail++; $display("FAIL stall_hold%0d: got v%b %h want v1 c", k, data_valid, data); end
            tick();
        end
        data_ready = 1'b1;
        n_tests++; if (data_valid !== 1'b1 || data !== 4'hC) begin n_fail++; $display("FAIL stall_rel0: got v%b %h want v1 c", data_valid, data); end
        tick();
        n_tests++; if (data_valid !== 1'b1 || data !== 4'h3) begin n_fail++; $display("FAIL stall_rel1: got v%b %h want v1 3", data_valid, data); end
        tick();
        n_tests++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL stall_end: got v%b want 0", data_valid); end
    endtask

    task automatic test_fill();
        int acc = 0;
        data_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            byte_valid = 1'b1;
            byte_data  = 8'(acc + 1);
            if (byte_ready === 1'b1) acc++;
            tick();
        end
        byte_valid = 1'b0;
        n_tests++; if (acc != 5) begin n_fail++; $display("FAIL fill_accepted: got %0d want 5", acc); end
        n_tests++; if (level !== LW'(DEPTH)) begin n_fail++; $display("FAIL fill_level: got %0d want %0d", level, DEPTH); end
        n_tests++; if (byte_ready !== 1'b0) begin n_fail++; $display("FAIL fill_ready: got %b want 0", byte_ready); end
`ifdef NIBBLE_FEEDER_STALL_CNT_EN
        n_tests++; if (stall_cnt !== 16'(m_stall)) begin n_fail++; $display("FAIL fill_stall_cnt: got %0d want %0d", stall_cnt, m_stall); end
`endif
        data_ready = 1'b1;
        for (int k = 0; k < 14; k++) begin
            n_tests++; if (data_valid !== (m_rem > 0)) begin n_fail++; $display("FAIL fill_drain_valid%0d: got %b want %b", k, data_valid, m_rem > 0); end
            if (m_rem > 0) begin
                n_tests++; if (data !== m_nib()) begin n_fail++; $display("FAIL fill_drain_nib%0d: got %h want %h", k, data, m_nib()); end
            end
            tick();
        end
        n_tests++; if (idle !== 1'b1) begin n_fail++; $display("FAIL fill_idle: got %b want 1", idle); end
    endtask

    task automatic test_simul();
        data_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            byte_valid = 1'b1; byte_data = 8'($urandom);
            tick();
        end
        byte_valid = 1'b0;
        tick();
        n_tests++; if (level !== LW'(2)) begin n_fail++; $display("FAIL simul_pre_level: got %0d want 2", level); end
        data_ready = 1'b1;
        for (int k = 0; k < 18; k++) begin
            // Offer a byte only on cycles where the stage hands off, so push and pop coincide.
            byte_valid = (m_rem == 1);
            byte_data  = 8'($urandom);
            tick();
            n_tests++; if (level !== LW'(2)) begin n_fail++; $display("FAIL simul_level%0d: got %0d want 2", k, level); end
            n_tests++; if (data_valid !== 1'b1 || data !== m_nib()) begin n_fail++; $display("FAIL simul_nib%0d: got v%b %h want v1 %h", k, data_valid, data, m_nib()); end
        end
        byte_valid = 1'b0;
        for (int k = 0; k < 8; k++) tick();
        n_tests++; if (idle !== 1'b1) begin n_fail++; $display("FAIL simul_idle: got %b want 1", idle); end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            byte_valid = ($urandom_range(0, 9) < 6);
            byte_data  = 8'($urandom);
            data_ready = ($urandom_range(0, 9) < 7);
            n_tests++; if (byte_ready !== (mq.size() < DEPTH)) begin n_fail++; $display("FAIL rand_ready%0d: got %b want %b", k, byte_ready, mq.size() < DEPTH); end
            tick();
            n_tests++; if (data_valid !== (m_rem > 0)) begin n_fail++; $display("FAIL rand_valid%0d: got %b want %b", k, data_valid, m_rem > 0); end
            if (m_rem > 0) begin
                n_tests++; if (data !== m_nib()) begin n_fail++; $display("FAIL rand_nib%0d: got %h want %h", k, data, m_nib()); end
            end
            n_tests++; if (level !== LW'(mq.size())) begin n_fail++; $display("FAIL rand_level%0d: got %0d want %0d", k, level, mq.size()); end
            n_tests++; if (idle !== (m_rem == 0 && mq.size() == 0)) begin n_fail++; $display("FAIL rand_idle%0d: got %b", k, idle); end
`ifdef NIBBLE_FEEDER_STALL_CNT_EN
            n_tests++; if (stall_cnt !== 16'(m_stall)) begin n_fail++; $display("FAIL rand_stall%0d: got %0d want %0d", k, stall_cnt, m_stall); end
`endif
        end
        byte_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        int guard = 0;
        data_ready = 1'b1;
        byte_valid = 1'b1; byte_data = 8'h9E; tick();
        byte_data = 8'h4B; tick();
        byte_valid = 1'b0;
        while (m_rem != 1 && guard < 10) begin tick(); guard++; end
        n_tests++; if (m_rem != 1 || data_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_setup: stage not in second nibble, valid %b", data_valid); end
        rst_n = 1'b0;
        tick();
        n_tests++; if (data_valid !== 1'b0 || level !== '0 || data !== 4'h0) begin
            n_fail++; $display("FAIL rmid_reset: got v%b lvl%0d d%h want v0 lvl0 d0", data_valid, level, data);
        end
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_tests++; if (data_valid !== 1'b0 || idle !== 1'b1) begin n_fail++; $display("FAIL rmid_resume%0d: got v%b idle%b want v0 idle1", k, data_valid, idle); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_fill();
        test_simul();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
